// File: rtl/rtcl_python_align_ctl.sv
// PYTHON LVDS word-alignment trainer: per-lane slip/settle/check FSMs
// that drive bitslip until each lane shows the training word stably.
module rtcl_python_align_ctl #(
   parameter int                 LANES         = 5,
   parameter int                 DATA_BITS     = 10,
   parameter logic [DATA_BITS-1:0] TRAIN_PATTERN = 10'h3A6,
   parameter int                 SETTLE_CYCLES = 4,
   parameter int                 MATCH_COUNT   = 16,
   parameter int                 MAX_SLIP      = 10,
   localparam int                SLIP_BITS     = $clog2(MAX_SLIP+1)
) (
   input  logic                           aresetn,
   input  logic                           aclk,
   input  logic                           start,
   input  logic                           abort,
   input  logic                           manual_en,
   input  logic [LANES-1:0]               manual_slip,
   input  logic [LANES*DATA_BITS-1:0]     s_data,
   input  logic                           s_valid,
   output logic [LANES-1:0]               bitslip,
   output logic [LANES-1:0]               aligned,
   output logic [LANES-1:0]               failed,
   output logic [LANES*SLIP_BITS-1:0]     slip_count,
   output logic                           busy,
   output logic                           done,
   output logic                           error
);

   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int MW = (MATCH_COUNT > 1) ? $clog2(MATCH_COUNT) : 1;
   localparam logic [SW-1:0]        SETTLE_LAST = SW'(SETTLE_CYCLES-1);
   localparam logic [MW-1:0]        MATCH_LAST  = MW'(MATCH_COUNT-1);
   localparam logic [SLIP_BITS-1:0] SLIP_MAX    = SLIP_BITS'(MAX_SLIP);

   typedef enum logic [2:0] {
      S_IDLE, S_SETTLE, S_CHECK, S_SLIP, S_ALIGNED, S_FAIL
   } state_e;

   logic             busy_q, done_q, error_q;
   logic [LANES-1:0] busy_l, term_l, fail_l;
   logic             kill, start_acc;

   // manual mode holds every lane FSM in IDLE, same as a sustained abort
   assign kill      = abort | manual_en;
   assign start_acc = start & ~kill & ~busy_q & ~(|busy_l);

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      state_e                 state_q;
      logic [SW-1:0]          settle_q;
      logic [MW-1:0]          match_q;
      logic [SLIP_BITS-1:0]   slip_q;
      logic                   bs_q, al_q, fl_q;
      logic [DATA_BITS-1:0]   word;

      assign word = s_data[i*DATA_BITS +: DATA_BITS];

      assign busy_l[i] = (state_q == S_SETTLE) | (state_q == S_CHECK) |
                         (state_q == S_SLIP);
      assign term_l[i] = (state_q == S_ALIGNED) | (state_q == S_FAIL);
      assign fail_l[i] = (state_q == S_FAIL);

      always_ff @(posedge aclk or negedge aresetn) begin
         if (!aresetn) begin
            state_q  <= S_IDLE;
            settle_q <= '0;
            match_q  <= '0;
            slip_q   <= '0;
            bs_q     <= 1'b0;
            al_q     <= 1'b0;
            fl_q     <= 1'b0;
         end else begin
            bs_q <= manual_en & manual_slip[i];
            al_q <= ~kill & ~start_acc & (state_q == S_ALIGNED);
            fl_q <= ~kill & ~start_acc & (state_q == S_FAIL);
            if (kill) begin
               state_q  <= S_IDLE;
               settle_q <= '0;
               match_q  <= '0;
               slip_q   <= '0;
            end else begin
               unique case (state_q)
                  S_IDLE, S_ALIGNED, S_FAIL: begin
                     if (start_acc) begin
                        state_q  <= S_SETTLE;
                        settle_q <= '0;
                        match_q  <= '0;
                        slip_q   <= '0;
                     end
                  end
                  S_SETTLE: begin
                     if (s_valid) begin
                        if (settle_q == SETTLE_LAST) begin
                           state_q <= S_CHECK;
                           match_q <= '0;
                        end else begin
                           settle_q <= settle_q + 1'b1;
                        end
                     end
                  end
                  S_CHECK: begin
                     if (s_valid) begin
                        if (word == TRAIN_PATTERN) begin
                           if (match_q == MATCH_LAST) state_q <= S_ALIGNED;
                           else match_q <= match_q + 1'b1;
                        end else if (slip_q == SLIP_MAX) begin
                           state_q <= S_FAIL;
                        end else begin
                           state_q <= S_SLIP;
                           bs_q    <= 1'b1;
                        end
                     end
                  end
                  S_SLIP: begin
                     slip_q   <= slip_q + 1'b1;
                     settle_q <= '0;
                     state_q  <= S_SETTLE;
                  end
                  default: state_q <= S_IDLE;
               endcase
            end
         end
      end

      assign bitslip[i]                          = bs_q;
      assign aligned[i]                          = al_q;
      assign failed[i]                           = fl_q;
      assign slip_count[i*SLIP_BITS +: SLIP_BITS] = slip_q;
   end

   // done marks the busy 1->0 edge caused by every lane finishing
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         busy_q  <= ~kill & (|busy_l);
         done_q  <= ~kill & busy_q & ~(|busy_l) & (&term_l);
         error_q <= ~kill & ~start_acc & (|fail_l);
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign error = error_q;

endmodule

// File: doc/rtcl_python_align_ctl.md
# rtcl_python_align_ctl

Word-alignment training controller for the PYTHON sensor LVDS receive path (4 data lanes plus sync lane). It watches the deserialized 10-bit words of every lane during sensor training. It issues one-cycle bitslip pulses per lane until each lane shows the training pattern stably, then reports per-lane aligned/failed status. It sits between the ISERDES/bitslip datapath and the register block; register writes can bypass it for manual bitslip.

## Interface
Parameters:
- LANES, 5, number of lanes (4 data + sync)
- DATA_BITS, 10, deserialized word width
- TRAIN_PATTERN, 10'h3A6, expected training word
- SETTLE_CYCLES, 4, valid beats ignored after each slip (≥1)
- MATCH_COUNT, 16, consecutive matching beats required for lock (≥1)
- MAX_SLIP, 10, slips allowed before a lane fails
- SLIP_BITS, $clog2(MAX_SLIP+1), local, slip counter width

Ports:
- aresetn  in  1  asynchronous reset, active-low
- aclk  in  1  deserialized word clock; single clock domain
- start  in  1  one-cycle pulse, begin training on all lanes
- abort  in  1  one-cycle pulse, return all lanes to IDLE
- manual_en  in  1  manual bitslip mode; automatic FSM held in IDLE
- manual_slip  in  LANES  per-lane manual slip pulse
- s_data  in  LANES*DATA_BITS  lane words, lane i at [i*DATA_BITS +: DATA_BITS]
- s_valid  in  1  word-valid qualifier for s_data
- bitslip  out  LANES  one-cycle bitslip pulse to the datapath
- aligned  out  LANES  lane locked
- failed  out  LANES  lane exhausted MAX_SLIP
- slip_count  out  LANES*SLIP_BITS  slips issued this run, per lane
- busy  out  1  any lane in SETTLE/CHECK/SLIP
- done  out  1  one-cycle pulse at end of a training run
- error  out  1  |failed

## Operation
- Each lane has an independent FSM: IDLE, SETTLE, CHECK, SLIP, ALIGNED, FAIL.
- IDLE: on accepted start, go to SETTLE. Clear slip_cnt, settle_cnt, aligned and failed.
- SETTLE: each s_valid increments settle_cnt. The beat with settle_cnt==SETTLE_CYCLES-1 moves to CHECK with match_cnt=0.
- CHECK, on s_valid, word==TRAIN_PATTERN: match_cnt++. At match_cnt==MATCH_COUNT-1 go to ALIGNED.
- CHECK, on s_valid, mismatch: if slip_cnt==MAX_SLIP go to FAIL; otherwise go to SLIP.
- SLIP: lasts exactly one cycle. slip_cnt++, settle_cnt=0, then go to SETTLE.
- ALIGNED/FAIL: hold until start or abort.
- Cycles without s_valid never advance counters.
- start is accepted only when busy=0 and manual_en=0. Otherwise it is ignored. A restart from ALIGNED/FAIL is allowed.
- abort, or manual_en rising, sends all lanes to IDLE. aligned, failed and slip_count are cleared. done does not pulse.
- If abort and start occur in the same cycle, abort wins.
- Manual mode (manual_en=1): bitslip = registered manual_slip; FSM pulses are suppressed.
- done pulses when busy falls 1→0 because all lanes reached ALIGNED or FAIL.
- error = |failed, registered.

## Timing
- Reset values: all outputs 0, all FSMs in IDLE, all counters 0.
- bitslip[i] is registered. It is high for exactly the one cycle after the CHECK mismatch beat, i.e. while the lane is in SLIP. Consecutive pulses on one lane are separated by ≥SETTLE_CYCLES+1 valid beats.
- Manual path: manual_slip[i] at cycle n gives bitslip[i] at cycle n+1, same width.
- Lock latency from start, lane already aligned, s_valid continuous: start at cycle 0 → ALIGNED entered at cycle SETTLE_CYCLES+MATCH_COUNT. aligned[i] is visible one cycle later. done is at the same cycle as the last aligned/failed bit rises.
- busy rises the cycle after accepted start. It falls in the same cycle that done pulses.
- slip_count updates in the SLIP cycle. It saturates at MAX_SLIP by construction.
- Asynchronous reset mid-run immediately returns every output to 0.

## Test plan
- All lanes receive 0x3A6 continuously, s_valid=1; pulse start → no bitslip; aligned=5'b11111 and done pulse at cycle 21; slip_count all 0; error=0.
- Lane 2 model rotates by one bit per bitslip, initial offset 3 → exactly 3 pulses on bitslip[2], each followed by ≥4 settle beats; slip_count[2]=3; all lanes aligned; one done.
- Lane 0 stuck at 10'h000 → 10 slips on lane 0, then failed[0]=1, error=1; lanes 1-4 aligned; one done after lane 0 fails.
- Inject one mismatching word on lane 1 after 10 matching beats → lane 1 slips once and match_cnt restarts; s_valid toggled 50% → lock latency doubles, no extra slips.
- abort mid-CHECK, and separately a second start while busy → abort clears status within 1 cycle with no done; the second start is ignored. aresetn low mid-run → all outputs 0.
- manual_en=1, manual_slip=5'b00100 pulse → bitslip=5'b00100 one cycle later; start is ignored; busy stays 0.
